inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Fetch stage directly upstream of the single-cycle datapath. It owns the architectural PC and fetches 32-bit instruction words from instruction memory over a req/ack handshake that tolerates variable latency. Fetched words are buffered in a small prefetch FIFO and presented to the datapath with a valid/ready handshake. Branch or jump redirects from the datapath flush the buffer and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, number of prefetch entries; legal values are 2 or 4.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req  out  1  instruction memory request.
imem_addr  out  32  word-aligned fetch address; held stable while imem_req=1.
imem_ack  in  1  memory completion; imem_rdata is valid in the same cycle.
imem_rdata  in  32  instruction word returned by memory.
redirect_valid  in  1  one-cycle pulse that replaces the fetch PC (taken branch or jump).
redirect_pc  in  32  redirect target; bits [1:0] are forced to 0 internally.
inst_valid  out  1  the FIFO head holds a valid instruction.
inst_ready  in  1  datapath consumes the head when inst_valid=1 and inst_ready=1.
instruction  out  32  FIFO head instruction word.
inst_pc  out  32  address of the head instruction.
inst_pc_plus4  out  32  inst_pc+4, modulo 2^32.

Behaviour:
- Reset is asynchronous, active-high. While reset=1 the outputs are:
  - imem_req=0, imem_addr=RESET_PC
  - inst_valid=0, instruction=0, inst_pc=0, inst_pc_plus4=4
  - FIFO count=0, FSM in IDLE, fetch_pc=RESET_PC.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding, response will be kept.
  - DROP: request outstanding, response will be discarded.
- IDLE -> REQ when count < FIFO_DEPTH and no redirect this cycle. imem_req and imem_addr are registered outputs and assert in the cycle after this decision.
- In REQ and DROP, imem_req=1 and imem_addr=fetch_pc. Both hold until imem_ack.
- Ack in REQ:
  - Push {imem_rdata, fetch_pc} into the FIFO.
  - fetch_pc <= fetch_pc+4, wrapping modulo 2^32.
  - If count-after-push < FIFO_DEPTH, stay in REQ with the new address; this gives back-to-back requests and one instruction per cycle for zero-wait memory. Otherwise go to IDLE.
- Ack in DROP: discard the data; go to REQ at fetch_pc, which already holds the redirect target.
- Redirect (highest priority):
  - Flush the FIFO: count=0 and inst_valid=0 next cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - From IDLE, go to REQ. From REQ without a same-cycle ack, go to DROP. From REQ or DROP with a same-cycle ack, discard the data and go to REQ at the target.
  - A redirect in the same cycle as a consumer pop: the flush wins; the pop is treated as completed.
  - A redirect while in DROP replaces the target and stays in DROP.
- Redirect latency: with zero-wait memory, the target instruction appears on inst_valid 2 cycles after the redirect cycle.
- FIFO behaviour:
  - Push and pop in the same cycle leave count unchanged, including when the FIFO is full.
  - The head outputs are driven from registers. Depth 2 or 4 uses a power-of-two pointer wrap.
  - When the FIFO is empty, instruction holds its last value and inst_valid=0.
- No instruction is ever duplicated or lost except by redirect flush.
- Reset asserted mid-transaction aborts immediately. A late imem_ack arriving after reset is ignored because the FSM is in IDLE.

Decomposition:
- Shared package fetch_pkg holds:
  - FSM state encoding: IDLE=2'b00, REQ=2'b01, DROP=2'b10.
  - WORD_BYTES=4.
  - NOP_INST=32'h0000_0000.
- One natural sub-module: fetch_fifo, a parameterised synchronous FIFO storing {pc, instruction} with push, pop, flush, count, full and empty.

Test Plan:
1. Reset release, RESET_PC=0, imem_ack tied to imem_req, inst_ready=1.
   -> imem_addr steps 0,4,8,... every cycle.
   -> inst_pc steps 0,4,8,... with inst_valid continuously high from cycle 2.
2. Memory latency 3 cycles, inst_ready=0.
   -> Exactly FIFO_DEPTH=2 words fetched (addresses 0, 4), then imem_req=0.
   -> Setting inst_ready=1 resumes fetch at address 8.
3. Redirect to 32'h40 while a request to address 8 is outstanding with 2 cycles remaining.
   -> The address-8 data is discarded, then imem_addr=32'h40.
   -> The first inst_pc after the flush is 32'h40.
4. Redirect to 32'h103 in the same cycle as an ack and a pop.
   -> FIFO empty next cycle.
   -> Next imem_addr=32'h100; the acked word never appears on instruction.
5. RESET_PC=32'hFFFF_FFFC, zero-wait memory.
   -> inst_pc goes FFFF_FFFC then 0000_0000; inst_pc_plus4=0 for the first instruction.
6. Reset asserted mid-request with imem_ack arriving 1 cycle after release.
   -> imem_req drops immediately; the stale ack is ignored.
   -> Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, word size,
// and the {pc, instruction} entry carried through the prefetch FIFO.
package fetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DROP = 2'b10;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(32'(WORD_BYTES) - 32'd1);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of the memory-side and datapath-side handshakes of the fetch unit.
// The fetch unit takes the master view; memory/datapath models take the slave view.
interface inst_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        output inst_valid, instruction, inst_pc, inst_pc_plus4,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        input  inst_valid, instruction, inst_pc, inst_pc_plus4,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instruction} entries with flush. The head entry and the
// empty flag are registered so the datapath sees flop outputs only.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    fetch_entry_t     head_q, head_d;
    logic             do_push, do_pop;

    assign full = (count_q == CNT_W'(DEPTH));

    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && !flush && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            // Next head bypasses storage when the entry being written becomes the head.
            if (count_d != '0)
                head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
        end
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            head_q   <= '{pc: 32'h0, inst: NOP_INST};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = head_q;
    assign count     = count_q;
    assign empty     = empty_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues word fetches over a variable-latency req/ack
// bus, buffers them in a prefetch FIFO and handles redirect flushes.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic               clock,
    input logic               reset,
    inst_fetch_unit_if.master bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             ack, push, pop, flush;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] count, count_after_push;
    fetch_entry_t     push_data, head;

    // A late ack while idle belongs to an aborted request and is ignored.
    assign ack              = bus.imem_ack && (state_q != ST_IDLE);
    assign pop              = !fifo_empty && bus.inst_ready;
    assign count_after_push = count + CNT_W'(1) - CNT_W'(pop);
    assign push_data        = '{pc: fetch_pc_q, inst: bus.imem_rdata};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (bus.redirect_valid) begin
            flush      = 1'b1;
            fetch_pc_d = word_align(bus.redirect_pc);
            // An outstanding request without ack must still be drained.
            state_d    = (state_q == ST_IDLE || ack) ? ST_REQ : ST_DROP;
        end else begin
            case (state_q)
                ST_IDLE: if (!fifo_full) state_d = ST_REQ;
                ST_REQ: begin
                    if (ack) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
                        state_d    = (count_after_push < CNT_W'(FIFO_DEPTH)) ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DROP: if (ack) state_d = ST_REQ;
                default: state_d = ST_IDLE;
            endcase
        end
        // The bus address only moves when no request is in flight.
        addr_d = (state_q == ST_IDLE || ack) ? fetch_pc_d : addr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head_data (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.imem_req      = (state_q != ST_IDLE);
    assign bus.imem_addr     = addr_q;
    assign bus.inst_valid    = !fifo_empty;
    assign bus.instruction   = head.inst;
    assign bus.inst_pc       = head.pc;
    assign bus.inst_pc_plus4 = head.pc + 32'(WORD_BYTES);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: memory model with programmable latency,
// scoreboard of expected {pc, instruction} entries popped on each consumption.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    inst_fetch_unit_if fif0 ();
    inst_fetch_unit_if fif1 ();

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut0 (
        .clock (clock), .reset (reset), .bus (fif0)
    );
    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_dut1 (
        .clock (clock), .reset (reset), .bus (fif1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_pop    = 0;
    int n_ack    = 0;
    int unsigned lat = 0;
    int unsigned wcnt;
    logic auto_en = 1'b0;
    logic man_ack = 1'b0;
    fetch_entry_t sb_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model for dut0: ack after 'lat' wait cycles, or a manual stray ack.
    assign fif0.imem_ack   = man_ack || (auto_en && fif0.imem_req && (wcnt >= lat));
    assign fif0.imem_rdata = man_ack ? 32'hDEAD_BEEF : inst_of(fif0.imem_addr);

    always @(posedge clock or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (fif0.imem_req && !fif0.imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clock) begin
        if (fif0.imem_req && fif0.imem_ack) n_ack <= n_ack + 1;
    end

    // dut1: zero-wait memory, always-ready consumer, no redirects.
    assign fif1.imem_ack       = fif1.imem_req;
    assign fif1.imem_rdata     = inst_of(fif1.imem_addr);
    assign fif1.redirect_valid = 1'b0;
    assign fif1.redirect_pc    = 32'h0;
    assign fif1.inst_ready     = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 32'(4 * i);
            e.inst = inst_of(e.pc);
            sb_q.push_back(e);
        end
    endtask

    // Scoreboard: every consumed head must match the next expected entry.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                sb_q.delete();
            end else begin
                if (fif0.inst_valid && fif0.inst_ready) begin
                    n_pop++;
                    check("sb_avail", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("inst_pc", fif0.inst_pc, e.pc);
                        check("instruction", fif0.instruction, e.inst);
                        check("inst_pc_plus4", fif0.inst_pc_plus4, e.pc + 32'd4);
                    end
                end
                if (fif0.redirect_valid) sb_q.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base_ack;
        logic found;

        reset = 1'b1;
        fif0.inst_ready     = 1'b0;
        fif0.redirect_valid = 1'b0;
        fif0.redirect_pc    = 32'h0;
        step();
        @(negedge clock);
        check("rst_imem_req", 32'(fif0.imem_req), 32'd0);
        check("rst_imem_addr", fif0.imem_addr, 32'h0);
        check("rst_inst_valid", 32'(fif0.inst_valid), 32'd0);
        check("rst_instruction", fif0.instruction, 32'h0);
        check("rst_inst_pc", fif0.inst_pc, 32'h0);
        check("rst_inst_pc_plus4", fif0.inst_pc_plus4, 32'd4);
        check("rst_dut1_addr", fif1.imem_addr, 32'hFFFF_FFFC);

        // Test 1: zero-wait streaming
        auto_en = 1'b1;
        lat = 0;
        fif0.inst_ready = 1'b1;
        step();
        reset = 1'b0;
        expect_seq(32'h0, 12);
        base = n_pop;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("t1_imem_addr", fif0.imem_addr, 32'(4 * (k - 1)));
            check("t1_imem_req", 32'(fif0.imem_req), 32'd1);
            if (k >= 2) check("t1_inst_valid", 32'(fif0.inst_valid), 32'd1);
        end
        step();
        check("t1_pops", 32'(n_pop - base), 32'd7);

        // Test 2: 3-cycle latency with a stalled consumer
        lat = 3;
        fif0.inst_ready = 1'b0;
        do_reset();
        expect_seq(32'h0, 8);
        base = n_pop;
        base_ack = n_ack;
        repeat (14) step();
        @(negedge clock);
        check("t2_req_idle", 32'(fif0.imem_req), 32'd0);
        check("t2_acks", 32'(n_ack - base_ack), 32'd2);
        check("t2_head_valid", 32'(fif0.inst_valid), 32'd1);
        check("t2_head_pc", fif0.inst_pc, 32'h0);
        step();
        fif0.inst_ready = 1'b1;
        for (int i = 0; i < 10 && !fif0.imem_req; i++) step();
        check("t2_resume_req", 32'(fif0.imem_req), 32'd1);
        check("t2_resume_addr", fif0.imem_addr, 32'h8);
        for (int i = 0; i < 40 && (n_pop - base) < 3; i++) step();
        check("t2_pops", 32'((n_pop - base) >= 3), 32'd1);

        // Test 3: redirect while the address-8 request is outstanding
        lat = 3;
        fif0.inst_ready = 1'b1;
        do_reset();
        expect_seq(32'h0, 8);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (fif0.imem_req && fif0.imem_addr == 32'h8 && wcnt == 1) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_found_req8", 32'(found), 32'd1);
        fif0.redirect_valid = 1'b1;
        fif0.redirect_pc    = 32'h40;
        step();
        fif0.redirect_valid = 1'b0;
        expect_seq(32'h40, 8);
        base = n_pop;
        @(negedge clock);
        check("t3_drop_addr", fif0.imem_addr, 32'h8);
        check("t3_drop_req", 32'(fif0.imem_req), 32'd1);
        check("t3_flush_valid", 32'(fif0.inst_valid), 32'd0);
        for (int i = 0; i < 10 && fif0.imem_addr == 32'h8; i++) step();
        check("t3_target_addr", fif0.imem_addr, 32'h40);
        check("t3_target_req", 32'(fif0.imem_req), 32'd1);
        for (int i = 0; i < 20 && (n_pop - base) < 2; i++) step();
        check("t3_pops", 32'((n_pop - base) >= 2), 32'd1);

        // Test 4: redirect coinciding with ack and pop
        lat = 0;
        do_reset();
        expect_seq(32'h0, 20);
        repeat (4) step();
        check("t4_pre_ack", 32'(fif0.imem_ack), 32'd1);
        check("t4_pre_valid", 32'(fif0.inst_valid), 32'd1);
        fif0.redirect_valid = 1'b1;
        fif0.redirect_pc    = 32'h103;
        step();
        fif0.redirect_valid = 1'b0;
        expect_seq(32'h100, 8);
        @(negedge clock);
        check("t4_flush_valid", 32'(fif0.inst_valid), 32'd0);
        check("t4_target_addr", fif0.imem_addr, 32'h100);
        check("t4_target_req", 32'(fif0.imem_req), 32'd1);
        step();
        @(negedge clock);
        check("t4_latency_valid", 32'(fif0.inst_valid), 32'd1);
        check("t4_latency_pc", fif0.inst_pc, 32'h100);

        // Test 5: PC wrap on dut1
        auto_en = 1'b0;
        fif0.inst_ready = 1'b0;
        do_reset();
        step();
        step();
        @(negedge clock);
        check("t5_valid", 32'(fif1.inst_valid), 32'd1);
        check("t5_pc_top", fif1.inst_pc, 32'hFFFF_FFFC);
        check("t5_plus4_wrap", fif1.inst_pc_plus4, 32'h0);
        check("t5_inst_top", fif1.instruction, inst_of(32'hFFFF_FFFC));
        step();
        @(negedge clock);
        check("t5_pc_wrap", fif1.inst_pc, 32'h0);
        check("t5_plus4", fif1.inst_pc_plus4, 32'h4);
        check("t5_inst_wrap", fif1.instruction, inst_of(32'h0));

        // Test 6: reset mid-request and a stale ack afterwards
        auto_en = 1'b0;
        fif0.inst_ready = 1'b1;
        do_reset();
        repeat (3) step();
        check("t6_pending_req", 32'(fif0.imem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_abort_req", 32'(fif0.imem_req), 32'd0);
        check("t6_abort_valid", 32'(fif0.inst_valid), 32'd0);
        step();
        reset   = 1'b0;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        @(negedge clock);
        check("t6_restart_req", 32'(fif0.imem_req), 32'd1);
        check("t6_restart_addr", fif0.imem_addr, 32'h0);
        repeat (3) step();
        check("t6_no_stale_push", 32'(fif0.inst_valid), 32'd0);
        expect_seq(32'h0, 8);
        base = n_pop;
        auto_en = 1'b1;
        lat = 0;
        for (int i = 0; i < 20 && (n_pop - base) < 2; i++) step();
        check("t6_pops", 32'((n_pop - base) >= 2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
